// File: rtl/predictor_pkg.sv
// predictor_pkg
//   Shared types and constants for the predictor output path.
//   PRED_ADDR_W  : jump address width carried by a queued record
//   FLUSH_CNT_W  : width of the optional restore-flush statistics counter
//   pred_entry_t : one queued prediction record {addr, preload, restore}
//   q_state_e    : queue occupancy state (EMPTY / PARTIAL / FULL)
package predictor_pkg;

   localparam int PRED_ADDR_W = 11;
   localparam int FLUSH_CNT_W = 16;

   typedef struct packed {
      logic [PRED_ADDR_W-1:0] addr;
      logic                   preload;
      logic                   restore;
   } pred_entry_t;

   typedef enum logic [1:0] {
      Q_EMPTY   = 2'd0,
      Q_PARTIAL = 2'd1,
      Q_FULL    = 2'd2
   } q_state_e;

endpackage

// File: rtl/predictor_entry_fifo.sv
// predictor_entry_fifo
//   Generic DEPTH-entry register FIFO of pred_entry_t records with a clear.
//   Ports:
//     clock, reset_n : rising-edge clock, asynchronous active-low reset
//     clear          : drop all entries; if push is also high, din becomes
//                      the only entry (clear takes priority over pop)
//     push, pop      : write din at tail / retire head (ignored when full /
//                      empty respectively)
//     din, dout      : record in / head record (undefined while empty)
//     occupancy      : entries held, 0..DEPTH
//     state          : occupancy state, exposed for observation
//   Handshake: the caller decides acceptance; this block only guards against
//   overflow and underflow.
module predictor_entry_fifo
   import predictor_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int CNT_W = $clog2(DEPTH+1),
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              clear,
   input  logic              push,
   input  logic              pop,
   input  pred_entry_t       din,
   output pred_entry_t       dout,
   output logic [CNT_W-1:0]  occupancy,
   output q_state_e          state
);

   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   pred_entry_t       mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr, rd_ptr, wr_ptr_next, rd_ptr_next, write_idx;
   logic [CNT_W-1:0]  count, count_next;
   logic              write_en, do_push, do_pop;
   q_state_e          state_next;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state  <= Q_EMPTY;
         count  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         state  <= state_next;
         count  <= count_next;
         wr_ptr <= wr_ptr_next;
         rd_ptr <= rd_ptr_next;
      end
   end

   always_comb begin
      wr_ptr_next = wr_ptr;
      rd_ptr_next = rd_ptr;
      count_next  = count;
      write_en    = 1'b0;
      write_idx   = wr_ptr;
      do_push     = 1'b0;
      do_pop      = 1'b0;
      if (clear) begin
         // Restart from slot 0 so the surviving record is the new head.
         rd_ptr_next = '0;
         if (push) begin
            write_en    = 1'b1;
            write_idx   = '0;
            wr_ptr_next = PTR_W'(1);
            count_next  = CNT_W'(1);
         end else begin
            wr_ptr_next = '0;
            count_next  = '0;
         end
      end else begin
         do_push = push && (count != FULL_CNT);
         do_pop  = pop && (count != '0);
         if (do_push) begin
            write_en    = 1'b1;
            wr_ptr_next = wr_ptr + 1'b1;  // power-of-two depth: natural wrap
         end
         if (do_pop) begin
            rd_ptr_next = rd_ptr + 1'b1;
         end
         if (do_push && !do_pop) begin
            count_next = count + 1'b1;
         end else if (!do_push && do_pop) begin
            count_next = count - 1'b1;
         end
      end
      if (count_next == '0) begin
         state_next = Q_EMPTY;
      end else if (count_next == FULL_CNT) begin
         state_next = Q_FULL;
      end else begin
         state_next = Q_PARTIAL;
      end
   end

   // Storage needs no reset: dout is only consumed while occupancy != 0.
   always_ff @(posedge clock) begin
      if (write_en) begin
         mem[write_idx] <= din;
      end
   end

   assign dout      = mem[rd_ptr];
   assign occupancy = count;

endmodule

// File: rtl/predictor_output_queue.sv
// predictor_output_queue
//   Registered ready/valid queue between the branch predictor and the
//   fetch/preload unit. A restore record clears every queued (stale)
//   prediction and becomes the only entry.
//   Ports:
//     clock, reset_n          : rising-edge clock, async active-low reset
//     in_valid / in_ready     : producer handshake (in_ready = not full)
//     jump_addr, preload,
//     restore                 : offered record
//     out_valid / out_ready   : consumer handshake for the head record
//     latched_jump_addr,
//     latched_preload,
//     latched_restore         : head record, forced to 0 while empty
//     occupancy               : entries held, 0..DEPTH
//     flush_count             : only with PREDICTOR_OUT_STATS_EN; saturating
//                               count of restores that discarded older entries
//   Handshake: a record is taken on a rising edge when in_valid is high and
//   either in_ready is high or the record is a restore (restores are always
//   taken, even when full); the head is retired when out_valid && out_ready.
//   in_ready and out_valid depend on registered state only.
module predictor_output_queue
   import predictor_pkg::*;
#(
   parameter  int ADDR_W = PRED_ADDR_W,  // must equal PRED_ADDR_W
   parameter  int DEPTH  = 4,            // power of two, >= 2
   localparam int CNT_W  = $clog2(DEPTH+1)
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [ADDR_W-1:0] jump_addr,
   input  logic              preload,
   input  logic              restore,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W-1:0] latched_jump_addr,
   output logic              latched_preload,
   output logic              latched_restore,
   output logic [CNT_W-1:0]  occupancy
`ifdef PREDICTOR_OUT_STATS_EN
   ,
   output logic [FLUSH_CNT_W-1:0] flush_count
`endif
);

   pred_entry_t       wr_entry, head;
   q_state_e          q_state;
   logic              push, restore_push, pop;

   assign out_valid    = (q_state != Q_EMPTY);
   assign in_ready     = (q_state != Q_FULL);
   assign push         = in_valid && (in_ready || restore);
   assign restore_push = push && restore;
   assign pop          = out_valid && out_ready;

   assign wr_entry = '{addr: jump_addr, preload: preload, restore: restore};

   predictor_entry_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clock     (clock),
      .reset_n   (reset_n),
      .clear     (restore_push),
      .push      (push),
      .pop       (pop),
      .din       (wr_entry),
      .dout      (head),
      .occupancy (occupancy),
      .state     (q_state)
   );

   assign latched_jump_addr = out_valid ? head.addr    : '0;
   assign latched_preload   = out_valid ? head.preload : 1'b0;
   assign latched_restore   = out_valid ? head.restore : 1'b0;

`ifdef PREDICTOR_OUT_STATS_EN
   logic discards;

   // An entry popped in the restore cycle was consumed, not discarded.
   assign discards = (occupancy > CNT_W'(1)) ||
                     ((occupancy == CNT_W'(1)) && !pop);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         flush_count <= '0;
      end else if (restore_push && discards && (flush_count != '1)) begin
         flush_count <= flush_count + 1'b1;
      end
   end
`endif

endmodule
